// File: rtl/line_stream.sv
// Bresenham line generator: one command in, every pixel of the segment out over valid/ready.
// Optional window clipping is enabled by defining LINE_CLIP_EN.
module line_stream #(
  parameter int unsigned WIDTH_BITS = 6,
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned CLIP_W     = 64,
  parameter int unsigned CLIP_H     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH_BITS:0]   x0,
  input  logic [WIDTH_BITS:0]   y0,
  input  logic [WIDTH_BITS:0]   x1,
  input  logic [WIDTH_BITS:0]   y1,
  input  logic [COLOR_BITS-1:0] color_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_BITS:0]   x,
  output logic [WIDTH_BITS:0]   y,
  output logic [COLOR_BITS-1:0] color_out,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned CW  = WIDTH_BITS + 1;
  localparam int unsigned DW  = WIDTH_BITS + 2;
  localparam int unsigned EW  = WIDTH_BITS + 3;
  localparam int unsigned E2W = WIDTH_BITS + 4;

`ifdef LINE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_e;

  state_e                 state_q, state_d;
  logic signed [CW-1:0]   x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
  logic signed [DW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic                   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0]   err_q, err_d;
  logic [COLOR_BITS-1:0]  color_q, color_d;
  logic                   valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic                   ready_q, ready_d, busy_q, busy_d;

  logic signed [DW-1:0]   ddx, ddy;
  logic signed [E2W-1:0]  e2;
  logic                   step_x, step_y, fire, at_end;

  function automatic logic visible(input logic signed [CW-1:0] px, input logic signed [CW-1:0] py);
    visible = !CLIP_EN || (px >= 0 && int'(px) < int'(CLIP_W) && py >= 0 && int'(py) < int'(CLIP_H));
  endfunction

  // Next-state, Bresenham step and registered-output precompute
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    color_d  = color_q;
    done_d   = 1'b0;
    ddx      = '0;
    ddy      = '0;
    e2       = '0;
    step_x   = 1'b0;
    step_y   = 1'b0;
    at_end   = (x_q == x1_q) && (y_q == y1_q);
    // A clipped pixel has valid_q low and advances without waiting for out_ready.
    fire     = valid_q ? out_ready : 1'b1;

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          x_d     = $signed(x0);
          y_d     = $signed(y0);
          x1_d    = $signed(x1);
          y1_d    = $signed(y1);
          color_d = color_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        ddx      = DW'(x1_q) - DW'(x_q);
        ddy      = DW'(y1_q) - DW'(y_q);
        dx_d     = (ddx < 0) ? -ddx : ddx;
        dy_d     = (ddy < 0) ? ddy : -ddy;
        sx_neg_d = !(x_q < x1_q);
        sy_neg_d = !(y_q < y1_q);
        err_d    = EW'(dx_d) + EW'(dy_d);
        state_d  = RUN;
      end
      RUN: begin
        if (fire) begin
          if (at_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            e2     = E2W'(err_q) + E2W'(err_q);
            step_x = e2 >= E2W'(dy_q);
            step_y = e2 <= E2W'(dx_q);
            err_d  = err_q + (step_x ? EW'(dy_q) : EW'(0)) + (step_y ? EW'(dx_q) : EW'(0));
            if (step_x) x_d = sx_neg_q ? x_q - CW'(1) : x_q + CW'(1);
            if (step_y) y_d = sy_neg_q ? y_q - CW'(1) : y_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RUN) && visible(x_d, y_d);
    last_d  = valid_d && (x_d == x1_d) && (y_d == y1_d);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
      color_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
      color_q  <= color_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign out_valid = valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign color_out = color_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_line_stream.sv
// Scoreboard bench for line_stream: reference pixel lists are queued at command issue and
// checked by an independent monitor against the output stream.
module tb_line_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [6:0] x0, y0, x1, y1;
  logic [7:0] color_in;
  logic       out_valid, out_ready;
  logic [6:0] x, y;
  logic [7:0] color_out;
  logic       out_last, done, busy;

  line_stream dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y),
    .color_out(color_out), .out_last(out_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int col;
    bit last;
  } pix_t;

  pix_t exp_q[$];
  int   exp_cnt_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  bit mon_en   = 0;

  int  line_pix   = 0;
  int  last_cyc   = -1;
  int  acc_cyc    = 0;
  bit  pend_first = 0;
  bit  prev_v = 0, prev_r = 0, prev_last = 0;
  logic [23:0] prev_bundle = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit vis(input int px, input int py);
`ifdef LINE_CLIP_EN
    return px >= 0 && px < 64 && py >= 0 && py < 64;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: integer Bresenham walk from the segment description
  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
    int dx, dy, sx, sy, err, e2, cx, cy, vcnt;
    dx = iabs(ax1 - ax0);
    dy = -iabs(ay1 - ay0);
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    cx = ax0;
    cy = ay0;
    vcnt = 0;
    for (int it = 0; it < 1000; it++) begin
      if (vis(cx, cy)) begin
        exp_q.push_back('{cx, cy, col, (cx == ax1 && cy == ay1)});
        vcnt++;
      end
      if (cx == ax1 && cy == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
`ifdef LINE_CLIP_EN
    exp_cnt_q.push_back(vcnt);
`else
    exp_cnt_q.push_back(((dx > -dy) ? dx : -dy) + 1);
`endif
  endtask

  task automatic send_cmd(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
    int n;
    n = 0;
    model(ax0, ay0, ax1, ay1, col);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    x0 = 7'(ax0); y0 = 7'(ay0); x1 = 7'(ax1); y1 = 7'(ay1);
    color_in = 8'(col);
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 3000) begin
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    x0 = 7'($urandom); y0 = 7'($urandom); x1 = 7'($urandom); y1 = 7'($urandom);
    color_in = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_cnt_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain", 64'(exp_cnt_q.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready generator: 0 = always ready, 1 = random, 2 = pattern 1,0,0
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops and compares each delivered pixel
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (prev_v && !prev_r)
        check("stall_stable", 64'({out_valid, out_last, color_out, y, x}), 64'(prev_bundle));
`ifndef LINE_CLIP_EN
      if (rdy_mode == 0 && prev_v && prev_r && !prev_last)
        check("throughput", 64'(out_valid), 64'd1);
`endif
      if (out_valid) begin
        if (pend_first) begin
`ifndef LINE_CLIP_EN
          check("first_latency", 64'(cyc - acc_cyc), 64'd2);
`endif
          pend_first = 0;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 64'(out_valid), 64'd0);
          end else begin
            pix_t e;
            e = exp_q.pop_front();
            check("pixel", 64'({out_last, color_out, y, x}),
                  64'({e.last, 8'(e.col), 7'(e.y), 7'(e.x)}));
          end
          line_pix++;
          if (out_last) last_cyc = cyc;
        end
      end
      if (done) begin
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          check("pixel_count", 64'(line_pix), 64'(exp_cnt_q.pop_front()));
        end
        if (last_cyc >= 0) check("done_timing", 64'(cyc - last_cyc), 64'd1);
        check("ready_at_done", 64'(cmd_ready), 64'd1);
        line_pix = 0;
        last_cyc = -1;
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc    = cyc;
        pend_first = 1;
      end
      prev_v      = out_valid;
      prev_r      = out_ready;
      prev_last   = out_last;
      prev_bundle = {out_valid, out_last, color_out, y, x};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    cmd_valid = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_outputs", 64'({out_valid, out_last, done, busy}), 64'd0);
    check("rst_pixel", 64'({color_out, y, x}), 64'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    rdy_mode = 0;
    send_cmd(0, 0, 5, 0, 8'h11);
    drain();
    send_cmd(3, 10, 1, 2, 8'h22);
    drain();
    send_cmd(7, 7, 7, 7, 8'h33);
    drain();
    @(negedge clk);
    check("degenerate_idle", 64'({busy, cmd_ready}), 64'b01);

    rdy_mode = 2;
    send_cmd(0, 0, 4, 4, 8'h44);
    drain();

    rdy_mode = 0;
    send_cmd(-64, -64, 63, 63, 8'h55);
    send_cmd(63, -64, -64, 63, 8'h66);
    send_cmd(-64, 63, 63, 40, 8'h77);
    drain();
    send_cmd(-3, 0, 2, 0, 8'h88);
    send_cmd(-10, -10, -5, -5, 8'h99);
    drain();

    for (int i = 0; i < 40; i++) begin
      rdy_mode = (i % 4 == 0) ? 0 : 1;
      send_cmd($urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64,
               $urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64,
               int'($urandom_range(0, 255)));
    end
    drain();

    // Abort a long line partway through with an asynchronous reset
    rdy_mode = 0;
    send_cmd(0, 0, 20, 0, 8'hA5);
    n = 0;
    while (line_pix < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_state", 64'({busy, cmd_ready}), 64'b01);
    exp_q.delete();
    exp_cnt_q.delete();
    line_pix = 0;
    last_cyc = -1;
    pend_first = 0;
    prev_v = 0;
    prev_r = 0;
    prev_last = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'({done, out_valid}), 64'd0);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    send_cmd(5, 3, 8, 1, 8'h5A);
    drain();

    repeat (5) @(negedge clk);
    check("final_idle", 64'({busy, out_valid, cmd_ready}), 64'b001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
